// File: rtl/bcd_to_binary.sv
// bcd_to_binary
//   Sequential reverse double-dabble converter: packed BCD in, unsigned
//   binary out. One shift/correct step per clock, 4*N_DIGITS steps per
//   conversion, start/busy/done handshake, result held until the next
//   conversion completes.
//
// Ports
//   i_clk_1mhz     in   1           system clock, rising edge
//   i_reset_n      in   1           asynchronous active-low reset
//   i_start        in   1           conversion request (ignored while busy)
//   i_bcd_data     in   4*N_DIGITS  packed BCD operand, digit 0 in [3:0]
//   o_busy         out  1           conversion in progress
//   o_done         out  1           one-cycle pulse, result/error updated
//   o_binary_data  out  BIN_W       converted value
//   o_error        out  1           last operand had a non-decimal digit
//
// Build option
//   BCD_CHECK_EN : when defined, an operand with any nibble > 9 completes
//                  with o_error=1 and o_binary_data=0. When undefined,
//                  o_error is tied low and no digit check exists.
//
// State  | meaning
// IDLE   | waiting for i_start; result outputs held
// CONV   | one shift/correct step per edge, 4*N_DIGITS steps

module bcd_to_binary #(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic                    i_clk_1mhz,
  input  logic                    i_reset_n,
  input  logic                    i_start,
  input  logic [4*N_DIGITS-1:0]   i_bcd_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BIN_W-1:0]        o_binary_data,
  output logic                    o_error
);

  localparam int DW    = 4 * N_DIGITS;
  localparam int STEPS = DW;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state;
  logic [CNT_W-1:0] step_cnt;
  logic [DW-1:0]    bcd_q;
  logic [DW-1:0]    acc_q;

  logic [2*DW-1:0]  pair_shift;
  logic [DW-1:0]    bcd_next;
  logic [DW-1:0]    acc_next;

  // Shift the {bcd, acc} pair right as one word so the bit leaving the
  // BCD side lands in the accumulator MSB; then undo the x2 weight that
  // crossed each digit boundary by taking 3 off any digit now >= 8.
  always_comb begin
    pair_shift = {bcd_q, acc_q} >> 1;
    acc_next   = pair_shift[DW-1:0];
    bcd_next   = pair_shift[2*DW-1:DW];
    for (int d = 0; d < N_DIGITS; d++) begin
      if (pair_shift[DW + 4*d +: 4] >= 4'd8)
        bcd_next[4*d +: 4] = pair_shift[DW + 4*d +: 4] - 4'd3;
    end
  end

`ifdef BCD_CHECK_EN
  logic bad_digit;
  logic err_q;

  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (i_bcd_data[4*d +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end
`else
  assign o_error = 1'b0;
`endif

  always_ff @(posedge i_clk_1mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      step_cnt      <= '0;
      bcd_q         <= '0;
      acc_q         <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_binary_data <= '0;
`ifdef BCD_CHECK_EN
      err_q         <= 1'b0;
      o_error       <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            bcd_q    <= i_bcd_data;
            acc_q    <= '0;
            step_cnt <= '0;
`ifdef BCD_CHECK_EN
            err_q    <= bad_digit;
`endif
            o_busy   <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd_q    <= bcd_next;
          acc_q    <= acc_next;
          step_cnt <= step_cnt + CNT_W'(1);
          if (step_cnt == LAST_STEP) begin
`ifdef BCD_CHECK_EN
            o_error       <= err_q;
            o_binary_data <= err_q ? '0 : acc_next[BIN_W-1:0];
`else
            o_binary_data <= acc_next[BIN_W-1:0];
`endif
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
`timescale 1ns/1ps

module tb_bcd_to_binary;

  logic        i_clk_1mhz = 1'b0;
  logic        i_reset_n  = 1'b0;
  logic        i_start    = 1'b0;
  logic [15:0] i_bcd_data = '0;
  logic        o_busy;
  logic        o_done;
  logic [13:0] o_binary_data;
  logic        o_error;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  // expected {binary, error}, pushed when a start is driven
  logic [14:0] sb[$];

  bcd_to_binary #(.N_DIGITS(4), .BIN_W(14)) dut (
    .i_clk_1mhz    (i_clk_1mhz),
    .i_reset_n     (i_reset_n),
    .i_start       (i_start),
    .i_bcd_data    (i_bcd_data),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_binary_data (o_binary_data),
    .o_error       (o_error)
  );

  always #5 i_clk_1mhz = ~i_clk_1mhz;

  // Result monitor: every done pulse must match the oldest expectation.
  always @(negedge i_clk_1mhz) begin
    if (o_done === 1'b1) begin
      logic [14:0] e;
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got bin=%0d err=%0b, no result expected",
                 o_binary_data, o_error);
      end else begin
        e = sb.pop_front();
        if ({o_binary_data, o_error} !== e) begin
          errors++;
          $display("FAIL result: got bin=%0d err=%0b, expected bin=%0d err=%0b",
                   o_binary_data, o_error, e[14:1], e[0]);
        end
      end
    end
  end

  function automatic logic [13:0] bcd_value(input logic [15:0] b);
    return 14'(b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0]);
  endfunction

  // Called right after a negedge; returns right after a negedge.
  task automatic run_one(input logic [15:0] bcd, input logic [13:0] eb,
                         input logic ee, input string nm);
    int  k;
    bit  seen;
    bit  busy_bad;
    sb.push_back({eb, ee});
    i_start    = 1'b1;
    i_bcd_data = bcd;
    @(negedge i_clk_1mhz);
    i_start    = 1'b0;
    i_bcd_data = 16'($urandom);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b expected 1", nm, o_busy);
    end
    k = 0; seen = 0; busy_bad = 0;
    while (!seen && k < 40) begin
      @(negedge i_clk_1mhz);
      k++;
      if (o_done === 1'b1) begin
        seen = 1;
        checks++;
        if (k != 16) begin
          errors++;
          $display("FAIL %s latency: got %0d edges expected 16", nm, k);
        end
        checks++;
        if (o_busy !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_at_done: got %b expected 0", nm, o_busy);
        end
      end else if (o_busy !== 1'b1) begin
        busy_bad = 1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done within 40 cycles, expected at 16", nm);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy_drop: busy went low before done, expected high", nm);
    end
    @(negedge i_clk_1mhz);
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse_width: got %b expected 0", nm, o_done);
    end
  endtask

  task automatic check_zero_outputs(input string nm);
    checks++;
    if ({o_busy, o_done, o_binary_data, o_error} !== 17'd0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b bin=%0d err=%b expected all 0",
               nm, o_busy, o_done, o_binary_data, o_error);
    end
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_start   = 1'b0;
    repeat (3) @(negedge i_clk_1mhz);
    check_zero_outputs("reset_state");
    i_reset_n = 1'b1;
    @(negedge i_clk_1mhz);
    check_zero_outputs("after_reset_release");
  endtask

  task automatic test_basic();
    run_one(16'h1234, 14'd1234, 1'b0, "basic_1234");
  endtask

  task automatic test_boundaries();
    run_one(16'h0000, 14'd0,    1'b0, "bound_0000");
    run_one(16'h9999, 14'd9999, 1'b0, "bound_9999");
    run_one(16'h0009, 14'd9,    1'b0, "bound_0009");
    run_one(16'h1000, 14'd1000, 1'b0, "bound_1000");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [15:0] b;
      b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      run_one(b, bcd_value(b), 1'b0, "random");
    end
  endtask

  task automatic test_busy_ignore();
    int k;
    int d0;
    bit seen;
    sb.push_back({14'd42, 1'b0});
    d0 = done_cnt;
    i_start    = 1'b1;
    i_bcd_data = 16'h0042;
    @(negedge i_clk_1mhz);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk_1mhz);
    i_start    = 1'b1;
    i_bcd_data = 16'h7777;
    @(negedge i_clk_1mhz);
    i_start = 1'b0;
    k = 5; seen = 0;
    while (!seen && k < 40) begin
      @(negedge i_clk_1mhz);
      k++;
      if (o_done === 1'b1) seen = 1;
    end
    checks++;
    if (k != 16) begin
      errors++;
      $display("FAIL ignore_latency: got %0d edges expected 16", k);
    end
    repeat (25) @(negedge i_clk_1mhz);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d pulses expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int t1;
    int t2;
    int seen;
    sb.push_back({14'd500, 1'b0});
    sb.push_back({14'd1, 1'b0});
    i_start    = 1'b1;
    i_bcd_data = 16'h0500;
    t = 0; t1 = -1; t2 = -1; seen = 0;
    while (seen < 2 && t < 80) begin
      @(negedge i_clk_1mhz);
      t++;
      if (t == 2 && seen == 1) i_start = 1'b0;
      if (o_done === 1'b1) begin
        seen++;
        if (seen == 1) begin
          t1 = t;
          i_bcd_data = 16'h0001;
          t = 0;
        end else begin
          t2 = t;
        end
      end
    end
    i_start = 1'b0;
    checks++;
    if (t1 != 17) begin
      errors++;
      $display("FAIL b2b_first_done: got negedge %0d expected 17", t1);
    end
    checks++;
    if (t2 != 17) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles expected 17", t2);
    end
    @(negedge i_clk_1mhz);
  endtask

  task automatic test_reset_abort();
    int d0;
    i_start    = 1'b1;
    i_bcd_data = 16'h8888;
    @(negedge i_clk_1mhz);
    i_start = 1'b0;
    repeat (5) @(negedge i_clk_1mhz);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: got %b expected 1", o_busy);
    end
    #2 i_reset_n = 1'b0;
    #1 check_zero_outputs("abort_async_clear");
    d0 = done_cnt;
    @(negedge i_clk_1mhz);
    i_reset_n = 1'b1;
    repeat (25) @(negedge i_clk_1mhz);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - d0);
    end
    run_one(16'h0100, 14'd100, 1'b0, "after_abort_0100");
  endtask

`ifdef BCD_CHECK_EN
  task automatic test_digit_check();
    run_one(16'h0A05, 14'd0, 1'b1, "check_0A05");
    run_one(16'h0005, 14'd5, 1'b0, "check_0005");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
`ifdef BCD_CHECK_EN
    test_digit_check();
`endif
    repeat (3) @(negedge i_clk_1mhz);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
